// File: rtl/price_pkg.sv
// Shared types and helpers for the price predictor: fixed-point format,
// controller state encoding and the wide-to-fix saturating conversion.
package price_pkg;

  localparam int DATA_W = 20;
  localparam int FRAC_W = 10;
  localparam int CNT_W  = 16;
  // Width used for intermediate signed arithmetic before clamping.
  localparam int WIDE_W = 2*DATA_W + 8;

  typedef logic signed [DATA_W-1:0] fix_t;

  typedef enum logic [0:0] {
    NOCOEF = 1'b0,
    RUN    = 1'b1
  } state_t;

  typedef struct packed {
    logic ovf;
    fix_t val;
  } sat_res_t;

  localparam logic signed [WIDE_W-1:0] WIDE_FIX_MAX =
    {{(WIDE_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] WIDE_FIX_MIN =
    {{(WIDE_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Clamp a wide signed value into fix_t range and report whether it clamped.
  function automatic sat_res_t sat_fix(input logic signed [WIDE_W-1:0] v);
    sat_res_t r;
    if (v > WIDE_FIX_MAX) begin
      r.val = fix_t'(WIDE_FIX_MAX);
      r.ovf = 1'b1;
    end else if (v < WIDE_FIX_MIN) begin
      r.val = fix_t'(WIDE_FIX_MIN);
      r.ovf = 1'b1;
    end else begin
      r.val = fix_t'(v);
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/price_predictor_fix_mac_sat.sv
// Registered shift-add-saturate stage for fixed-point products:
//   res <= clamp(addend + (prod >>> FRAC_W)) on en, cleared by clr.
// The shift keeps the top bits of the product, i.e. truncation toward -inf.
// The sum is formed wide enough that no intermediate wrap can hide overflow.
module fix_mac_sat #(
  parameter int PROD_W = 40,
  parameter int ADD_W  = 20,
  parameter int OUT_W  = 20,
  parameter int FRAC_W = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [PROD_W-1:0] prod,
  input  logic signed [ADD_W-1:0]  addend,
  output logic signed [OUT_W-1:0]  res,
  output logic                     ovf
);
  import price_pkg::*;

  localparam int SH_W   = PROD_W - FRAC_W;
  localparam int MAX_IN = (SH_W > ADD_W) ? SH_W : ADD_W;
  localparam int SUM_W  = ((MAX_IN > OUT_W) ? MAX_IN : OUT_W) + 1;

  localparam logic signed [SUM_W-1:0] OUT_MAX =
    {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] OUT_MIN =
    {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [SH_W-1:0]  shifted_s;
  logic signed [SUM_W-1:0] sum_s;
  logic signed [OUT_W-1:0] res_s;
  logic                    ovf_s;

  assign shifted_s = prod[PROD_W-1:FRAC_W];
  assign sum_s     = SUM_W'(shifted_s) + SUM_W'(addend);

  // Clamp the wide sum into the output range.
  always_comb begin
    res_s = '0;
    ovf_s = 1'b0;
    if (sum_s > OUT_MAX) begin
      res_s = OUT_MAX[OUT_W-1:0];
      ovf_s = 1'b1;
    end else if (sum_s < OUT_MIN) begin
      res_s = OUT_MIN[OUT_W-1:0];
      ovf_s = 1'b1;
    end else begin
      res_s = sum_s[OUT_W-1:0];
      ovf_s = 1'b0;
    end
  end

  // Result register: clear wins over load; holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      res <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      res <= res_s;
      ovf <= ovf_s;
    end
  end

endmodule

// File: rtl/price_predictor.sv
// Linear price predictor: y_hat = B0 + B1*x through a two-stage pipeline
// with valid/ready flow control. Coefficients are latched on coef_load and
// travel with each beat so a reload never disturbs beats already in flight.
// Optional feature macro PRED_ERROR_EN adds a running sum of squared
// residuals against a target price carried with each beat.
module price_predictor #(
  parameter int DATA_W = price_pkg::DATA_W,
  parameter int FRAC_W = price_pkg::FRAC_W,
  parameter int CNT_W  = price_pkg::CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     coef_load,
  input  logic signed [DATA_W-1:0] b0_in,
  input  logic signed [DATA_W-1:0] b1_in,
  input  logic                     x_valid,
  output logic                     x_ready,
  input  logic signed [DATA_W-1:0] x_in,
  output logic                     y_valid,
  input  logic                     y_ready,
  output logic signed [DATA_W-1:0] y_hat,
  output logic                     sat_flag,
`ifdef PRED_ERROR_EN
  input  logic signed [DATA_W-1:0] y_true_in,
  output logic [2*DATA_W+7:0]      sse,
  input  logic                     sse_clr,
`endif
  output logic [CNT_W-1:0]         pred_cnt
);
  import price_pkg::*;

  state_t                    state_r, state_nx;
  logic signed [DATA_W-1:0]  b0_r, b1_r;
  logic                      v1_r, v2_r;
  logic signed [2*DATA_W-1:0] p1_r;
  logic signed [DATA_W-1:0]  b0_1_r;
  logic [CNT_W-1:0]          cnt_r;
  logic                      run_s, x_xfer_s, y_xfer_s, load2_s;

  assign run_s    = (state_r == RUN);
  // Stage 1 may only hand over when stage 2 is empty or being drained.
  assign load2_s  = v1_r & (~v2_r | y_ready);
  assign x_ready  = run_s & (~v2_r | y_ready | ~v1_r);
  assign x_xfer_s = x_valid & x_ready;
  assign y_xfer_s = v2_r & y_ready;
  assign y_valid  = v2_r;
  assign pred_cnt = cnt_r;

  // Controller state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= NOCOEF;
    else        state_r <= state_nx;
  end

  // Next state: wait for coefficients, then run forever.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      NOCOEF:  if (coef_load) state_nx = RUN; else state_nx = NOCOEF;
      RUN:     state_nx = RUN;
      default: state_nx = NOCOEF;
    endcase
  end

  // Coefficient latch; reload allowed at any time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b0_r <= '0;
      b1_r <= '0;
    end else if (coef_load) begin
      b0_r <= b0_in;
      b1_r <= b1_in;
    end
  end

  // Stage 1: product plus a private copy of B0 for this beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_r   <= 1'b0;
      p1_r   <= '0;
      b0_1_r <= '0;
    end else begin
      if (x_xfer_s) begin
        p1_r   <= b1_r * x_in;
        b0_1_r <= b0_r;
      end
      if (x_xfer_s)     v1_r <= 1'b1;
      else if (load2_s) v1_r <= 1'b0;
    end
  end

  // Stage 2 valid: filled from stage 1, emptied by an output transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        v2_r <= 1'b0;
    else if (load2_s)  v2_r <= 1'b1;
    else if (y_xfer_s) v2_r <= 1'b0;
  end

  fix_mac_sat #(
    .PROD_W(2*DATA_W), .ADD_W(DATA_W), .OUT_W(DATA_W), .FRAC_W(FRAC_W)
  ) u_price (
    .clk(clk), .reset(reset), .clr(1'b0), .en(load2_s),
    .prod(p1_r), .addend(b0_1_r), .res(y_hat), .ovf(sat_flag)
  );

  // Count accepted outputs; wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        cnt_r <= '0;
    else if (y_xfer_s) cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  end

`ifdef PRED_ERROR_EN
  logic signed [DATA_W-1:0]   yt1_r, yt2_r;
  sat_res_t                   r_s;
  fix_t                       r_val_s;
  logic signed [2*DATA_W-1:0] rsq_s;

  // Target price rides alongside its beat through both stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      yt1_r <= '0;
      yt2_r <= '0;
    end else begin
      if (x_xfer_s) yt1_r <= y_true_in;
      if (load2_s)  yt2_r <= yt1_r;
    end
  end

  assign r_s     = sat_fix(WIDE_W'(yt2_r) - WIDE_W'(y_hat));
  assign r_val_s = r_s.val;
  assign rsq_s   = r_val_s * r_val_s;

  fix_mac_sat #(
    .PROD_W(2*DATA_W), .ADD_W(2*DATA_W+8), .OUT_W(2*DATA_W+8), .FRAC_W(FRAC_W)
  ) u_sse (
    .clk(clk), .reset(reset), .clr(sse_clr), .en(y_xfer_s),
    .prod(rsq_s), .addend($signed(sse)), .res(sse), .ovf()
  );
`endif

endmodule
